// File: rtl/score_display.sv
// score_display: per-player rally counter with match-win detection, driving a
// 4-digit multiplexed seven-segment display. Digit3 shows player one's score,
// digit0 shows player two's, and the middle pair shows dashes during play or a
// blinking "P1"/"P2" banner once the match is won.
`timescale 1ns/100ps
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int WIN_POINTS  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_one,
  input  logic       point_two,
  input  logic       new_game,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    WIN_SCORE  = 4'(WIN_POINTS);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;

  typedef enum logic {PLAY, WON} state_t;

  state_t        state_q, state_d;
  logic [3:0]    score_one_q, score_one_d;
  logic [3:0]    score_two_q, score_two_d;
  logic [1:0]    winner_q, winner_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    scan_q, scan_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          blink_on_q, blink_on_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  // Active-low decimal decode; anything above 9 is shown blank.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Match state and scores; new_game wins over any point, simultaneous points cancel.
  always_comb begin
    state_d     = state_q;
    score_one_d = score_one_q;
    score_two_d = score_two_q;
    winner_d    = winner_q;
    if (new_game) begin
      state_d     = PLAY;
      score_one_d = 4'd0;
      score_two_d = 4'd0;
      winner_d    = 2'b00;
    end else if (state_q == PLAY && (point_one ^ point_two)) begin
      if (point_one) begin
        score_one_d = score_one_q + 4'd1;
        if (score_one_q + 4'd1 == WIN_SCORE) begin
          state_d  = WON;
          winner_d = 2'b01;
        end
      end else begin
        score_two_d = score_two_q + 4'd1;
        if (score_two_q + 4'd1 == WIN_SCORE) begin
          state_d  = WON;
          winner_d = 2'b10;
        end
      end
    end
  end

  // Free-running digit scan; new_game deliberately leaves it alone.
  always_comb begin
    if (ref_q == REF_LAST) begin
      ref_d  = '0;
      scan_d = scan_q + 2'd1;
    end else begin
      ref_d  = ref_q + 1'b1;
      scan_d = scan_q;
    end
  end

  // Banner blink: parked at 0/on until the cycle after WON is entered, so the first on-period is full length.
  always_comb begin
    blink_d    = '0;
    blink_on_d = 1'b1;
    if (state_d == WON && state_q == WON) begin
      if (blink_q == BLINK_LAST) begin
        blink_d    = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blink_d    = blink_q + 1'b1;
        blink_on_d = blink_on_q;
      end
    end
  end

  // Segment pattern built from next-state values so seg and an update on the same edge.
  always_comb begin
    an_d = ~(4'b0001 << scan_d);
    case (scan_d)
      2'd3: seg_d = dec7(score_one_d);
      2'd0: seg_d = dec7(score_two_d);
      2'd2: begin
        if (state_d != WON)  seg_d = SEG_DASH;
        else if (blink_on_d) seg_d = SEG_P;
        else                 seg_d = SEG_BLANK;
      end
      default: begin
        if (state_d != WON)  seg_d = SEG_DASH;
        else if (blink_on_d) seg_d = (winner_d == 2'b10) ? SEG_TWO : SEG_ONE;
        else                 seg_d = SEG_BLANK;
      end
    endcase
  end

  // All state, including the display pins, is registered with an asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PLAY;
      score_one_q <= 4'd0;
      score_two_q <= 4'd0;
      winner_q    <= 2'b00;
      ref_q       <= '0;
      scan_q      <= 2'd0;
      blink_q     <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      score_one_q <= score_one_d;
      score_two_q <= score_two_d;
      winner_q    <= winner_d;
      ref_q       <= ref_d;
      scan_q      <= scan_d;
      blink_q     <= blink_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign game_over = (state_q == WON);
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_display.sv
// Testbench for score_display (REFRESH_DIV=4, BLINK_DIV=8, WIN_POINTS=3).
// Stimulus pushes expected display snapshots keyed by cycle number into a
// queue; a separate monitor pops and compares them as the cycles arrive.
`timescale 1ns/100ps
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       point_one = 1'b0;
  logic       point_two = 1'b0;
  logic       new_game  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       game_over;
  logic [1:0] winner;

  score_display #(.REFRESH_DIV(4), .BLINK_DIV(8), .WIN_POINTS(3)) dut (
    .clk(clk), .rst(rst), .point_one(point_one), .point_two(point_two),
    .new_game(new_game), .seg(seg), .an(an), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; equals the DUT's scan position.
  int n;
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       go;
    logic [1:0] win;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event imm_ev;

  logic [6:0] dig [0:3];
  initial begin
    dig[0] = 7'b1000000;
    dig[1] = 7'b1111001;
    dig[2] = 7'b0100100;
    dig[3] = 7'b0110000;
  end

  task automatic push_one(input int nn, input logic [3:0] a, input logic [6:0] s,
                          input logic g, input logic [1:0] w, input string nm);
    exp_t e;
    e.n = nn; e.an = a; e.seg = s; e.go = g; e.win = w; e.nm = nm;
    q.push_back(e);
  endtask

  // Expected display for cycles a..b given the scores and match status.
  task automatic push_win(input int a, input int b, input int s1, input int s2,
                          input bit won, input bit w2, input int nw, input string nm);
    for (int k = a; k <= b; k++) begin
      int         sc;
      bit         on;
      logic [3:0] ea;
      logic [6:0] es;
      sc = (k / 4) % 4;
      on = (((k - nw) / 8) % 2) == 0;
      case (sc)
        0: ea = 4'b1110;
        1: ea = 4'b1101;
        2: ea = 4'b1011;
        default: ea = 4'b0111;
      endcase
      case (sc)
        3: es = dig[s1];
        0: es = dig[s2];
        2: es = !won ? 7'b0111111 : (on ? 7'b0001100 : 7'b1111111);
        default: es = !won ? 7'b0111111 : (on ? (w2 ? 7'b0100100 : 7'b1111001) : 7'b1111111);
      endcase
      push_one(k, ea, es, won, won ? (w2 ? 2'b10 : 2'b01) : 2'b00, nm);
    end
  endtask

  task automatic wait_n(input int k);
    while (n < k) @(negedge clk);
  endtask

  task automatic pulse(input logic p1, input logic p2, input logic ng);
    point_one = p1; point_two = p2; new_game = ng;
    @(negedge clk);
    point_one = 1'b0; point_two = 1'b0; new_game = 1'b0;
  endtask

  // Monitor: compares every due expectation at the falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or imm_ev);
      while (q.size() > 0 && q[0].n <= n) begin
        e = q.pop_front();
        checks++;
        if (e.n != n || an !== e.an || seg !== e.seg || game_over !== e.go || winner !== e.win) begin
          errors++;
          $display("FAIL %s cyc=%0d (due %0d): got an=%b seg=%b go=%b win=%b, want an=%b seg=%b go=%b win=%b",
                   e.nm, n, e.n, an, seg, game_over, winner, e.an, e.seg, e.go, e.win);
        end
      end
    end
  end

  initial begin
    #12;
    push_one(0, 4'b1110, 7'b1000000, 1'b0, 2'b00, "reset_hold");
    -> imm_ev;
    #10 rst = 1'b1;

    push_win(1, 27, 0, 0, 0, 0, 0, "scan");
    wait_n(27);
    push_win(28, 43, 1, 0, 0, 0, 0, "p1_first");
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(43);
    push_win(44, 47, 2, 0, 0, 0, 0, "p1_second");
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(47);
    push_win(48, 63, 2, 1, 0, 0, 0, "p2_first");
    pulse(1'b0, 1'b1, 1'b0);
    wait_n(63);
    push_win(64, 81, 2, 1, 0, 0, 0, "simultaneous");
    pulse(1'b1, 1'b1, 1'b0);
    wait_n(81);
    push_win(82, 113, 3, 1, 1, 0, 82, "win_blink");
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(95);
    pulse(1'b0, 1'b1, 1'b0);
    wait_n(113);
    push_win(114, 129, 0, 0, 0, 0, 0, "new_game_prio");
    pulse(1'b0, 1'b1, 1'b1);
    wait_n(129);
    push_win(130, 131, 1, 0, 0, 0, 0, "rescore_a");
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(131);
    push_win(132, 133, 1, 1, 0, 0, 0, "rescore_b");
    pulse(1'b0, 1'b1, 1'b0);
    wait_n(133);
    push_win(134, 140, 1, 2, 0, 0, 0, "rescore_c");
    pulse(1'b0, 1'b1, 1'b0);
    wait_n(140);

    #2 rst = 1'b0;
    #0.5;
    push_one(0, 4'b1110, 7'b1000000, 1'b0, 2'b00, "async_reset");
    -> imm_ev;
    #0.5 rst = 1'b1;
    push_win(1, 8, 0, 0, 0, 0, 0, "after_reset");
    wait_n(8);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d expectations left unchecked, want 0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the rally logic in the tennis game.
- Counts rallies won by each player from single-cycle point pulses and detects the match winner.
- Drives the board's 4-digit multiplexed seven-segment display with both scores and a blinking "P1"/"P2" banner once the match is won.
- Sits between the ball/player stage and the display pins; new_game comes from a debounced button pulse.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is lit before the scan advances (>=2).
- BLINK_DIV, 25000000, clk cycles per on/off half-period of the winner banner (>=2).
- WIN_POINTS, 7, points needed to win the match (1..9).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- point_one  input  1  single-cycle pulse: player one won a rally.
- point_two  input  1  single-cycle pulse: player two won a rally.
- new_game  input  1  single-cycle pulse (debounced): clear scores and start a new match.
- seg  output  7  segments, active-low, seg[6]=g ... seg[0]=a.
- an  output  4  digit anodes, active-low, one-hot-low.
- game_over  output  1  high while in WON state.
- winner  output  2  01 = player one, 10 = player two, 00 = none.

Behaviour:
- States: PLAY, WON. Reset (rst=0, async) forces PLAY, score_one=score_two=0, winner=00, game_over=0, scan index=0, refresh counter=0, blink counter=0, blink phase=on, an=1110, seg=1000000 (digit "0").
- Scores are 4-bit registers, range 0..WIN_POINTS. They never wrap.
- In PLAY, point_one alone increments score_one at that edge; the new value is visible the following cycle. point_two is handled the same way for score_two.
- point_one and point_two in the same cycle: both ignored, no score change.
- If an increment makes a score equal WIN_POINTS, the same edge enters WON, sets game_over=1 and sets winner to 01 or 10.
- In WON, points are ignored and scores are frozen.
- new_game in any state: clears both scores, sets winner=00, game_over=0, and enters PLAY. It takes priority over a simultaneous point pulse, which is dropped. The scan counters are not disturbed.
- Refresh counter runs 0..REFRESH_DIV-1 continuously. At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
- an is low only at bit [scan index]. seg is registered alongside an, so there is no mismatched digit/anode cycle.
- Digit contents:
  - Digit3 shows score_one.
  - Digit0 shows score_two.
  - In PLAY, digits 2 and 1 show dash (0111111).
  - In WON with blink phase on: digit2 = "P" (0001100) and digit1 = winner number ("1" = 1111001, "2" = 0100100).
  - In WON with blink phase off: digits 2 and 1 are blank (1111111). Scores stay lit.
- Decimal decode is active-low standard, e.g. 0=1000000, 3=0110000, 7=1111000.
- Blink counter is held at 0 with phase=on outside WON. On entry to WON the first on-period lasts BLINK_DIV cycles, then the phase toggles every BLINK_DIV cycles.
- Reset mid-match returns immediately to the reset values, regardless of clock.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8, WIN_POINTS=3):
- Reset and scan: hold rst=0, then release and run 16 cycles → an sequence 1110,1101,1011,0111 with 4 cycles each. seg per digit = 1000000, 0111111, 0111111, 1000000. game_over=0, winner=00.
- Scoring: 2 point_one pulses and 1 point_two pulse → score_one=2, score_two=1 one cycle after each pulse. Digit3 seg=0100100, digit0 seg=1111001.
- Simultaneous pulses: point_one and point_two in the same cycle → both scores unchanged.
- Win: from 2-1, pulse point_one → next cycle game_over=1, winner=01, digit3 seg=0110000.
  - Digits 2 and 1 show 0001100 and 1111001 for 8 cycles, then 1111111 for 8 cycles, repeating.
  - A further point_two pulse leaves score_two=1.
- New game priority: in WON, new_game and point_two in the same cycle → next cycle scores 0/0, winner=00, game_over=0, state PLAY, digits 2 and 1 show dashes.
- Async reset: at score 1-2, pulse rst low for 1 ns between clock edges → outputs return to reset values immediately, without waiting for a clock edge.
